// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits are served in the request cycle without stalling. A miss stalls the CPU
// while the line is exchanged with the word-wide data memory. A dirty victim is
// written back first, then the new block is fetched, and the line is updated.
module data_cache_dm #(
  parameter int ADDR_W      = 8,
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      READ,
  input  logic                                      WRITE,
  input  logic [ADDR_W-1:0]                         ADDRESS,
  input  logic [7:0]                                WRITEDATA,
  output logic [7:0]                                READDATA,
  output logic                                      BUSYWAIT,
  output logic                                      MEM_READ,
  output logic                                      MEM_WRITE,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]     MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0]                  MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0]                  MEM_READDATA,
  input  logic                                      MEM_BUSYWAIT
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_t;

  // Controller state and registered memory-request strobes
  state_t              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;

  // Per-line status, tag and data storage
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   data_d [NUM_SETS];

  // Block captured from memory when the fetch completes, installed in UPDATE
  logic [LINE_W-1:0]   fill_q, fill_d;

  // Address decode of the current CPU request
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic                req_any;
  logic                req_rd;
  logic                hit;
  logic                victim_dirty;
  logic [LINE_W-1:0]   cur_line;
  logic [LINE_W-1:0]   merged_line;
  logic [7:0]          sel_byte;

  assign req_tag      = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_idx      = ADDRESS[OFF_W +: IDX_W];
  assign req_off      = ADDRESS[OFF_W-1:0];
  assign req_any      = READ | WRITE;
  // READ and WRITE together is illegal; the store wins.
  assign req_rd       = READ & ~WRITE;
  assign hit          = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
  assign cur_line     = data_q[req_idx];

  // Byte lane selection and store merge for the addressed line
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a value held (no latch).
    sel_byte    = cur_line[{req_off, 3'b000} +: 8];
    merged_line = cur_line;
    merged_line[{req_off, 3'b000} +: 8] = WRITEDATA;
  end

  // Next-state, array-update and memory-request decode
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    fill_d  = fill_q;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (hit) begin
            if (WRITE) begin
              data_d[req_idx]  = merged_line;
              dirty_d[req_idx] = 1'b1;
            end
          end else if (victim_dirty) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!MEM_BUSYWAIT) begin
          fill_d  = MEM_READDATA;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        data_d[req_idx]  = fill_q;
        tag_d[req_idx]   = req_tag;
        valid_d[req_idx] = 1'b1;
        dirty_d[req_idx] = 1'b0;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_read_d  = (state_d == S_FETCH);
    mem_write_d = (state_d == S_WRITEBACK);
  end

  // Control state and line status; synchronous active-low reset aborts any miss
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Tag, data and fill storage; contents are qualified by valid_q
  always_ff @(posedge CLK) begin
    // NOTE: storage arrays are deliberately not reset; valid_q alone decides
    // whether a line's tag and data mean anything.
    tag_q  <= tag_d;
    data_q <= data_d;
    fill_q <= fill_d;
  end

  // CPU-side responses are combinational so hits cost no stall cycle
  always_comb begin
    BUSYWAIT = 1'b1;
    READDATA = '0;
    if (state_q == S_IDLE) begin
      BUSYWAIT = req_any & ~hit;
      if (req_rd && hit) begin
        READDATA = sel_byte;
      end
    end
  end

  // Memory-side address: victim block during write-back, requested block otherwise
  always_comb begin
    MEM_ADDRESS = ADDRESS[ADDR_W-1:OFF_W];
    if (state_q == S_WRITEBACK) begin
      MEM_ADDRESS = {tag_q[req_idx], req_idx};
    end
  end

  assign MEM_WRITEDATA = cur_line;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;

endmodule

// File: tb/tb_data_cache_dm.sv
// Directed testbench for data_cache_dm with a behavioural word-wide memory
// that holds MEM_BUSYWAIT high for MEM_LAT cycles per request.
module tb_data_cache_dm;

  localparam int MEM_LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model state and transaction log
  logic [31:0] mem_words [64];
  logic        mem_loaded = 1'b0;
  int          mem_cnt    = 0;
  int          wb_count   = 0;
  int          rd_count   = 0;
  logic [5:0]  wb_addr    = '0;
  logic [31:0] wb_data    = '0;
  logic [5:0]  rd_addr    = '0;
  logic        both_seen  = 1'b0;

  data_cache_dm dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < MEM_LAT);
  assign MEM_READDATA = mem_words[MEM_ADDRESS];

  // Memory model: preload once, count busy cycles, complete and log requests
  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_words[i] <= 32'h0;
      mem_words[6'h00] <= 32'h44332211;
      mem_words[6'h02] <= 32'h0BADF00D;
      mem_words[6'h08] <= 32'h88776655;
      mem_words[6'h11] <= 32'hDDCCBBAA;
      mem_words[6'h19] <= 32'h12345678;
      mem_loaded <= 1'b1;
    end
    if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both_seen <= 1'b1;
    if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
      if (mem_cnt < MEM_LAT) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (MEM_WRITE === 1'b1) begin
          mem_words[MEM_ADDRESS] <= MEM_WRITEDATA;
          wb_count <= wb_count + 1;
          wb_addr  <= MEM_ADDRESS;
          wb_data  <= MEM_WRITEDATA;
        end else begin
          rd_count <= rd_count + 1;
          rd_addr  <= MEM_ADDRESS;
        end
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one CPU access at a negedge; returns stall samples and the load byte.
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int stalls, output logic [7:0] rdata);
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITEDATA = wd;
    stalls = 0;
    #1;
    while (BUSYWAIT !== 1'b0 && stalls < 200) begin
      stalls++;
      @(negedge CLK);
      #1;
    end
    rdata = READDATA;
    @(negedge CLK);
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    READ = 1'b0;
    WRITE = 1'b0;
    ADDRESS = 8'h00;
    WRITEDATA = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_err++; $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
    n_cmp++; if (MEM_READ !== 1'b0) begin n_err++; $display("FAIL reset_mem_read: got %b want 0", MEM_READ); end
    n_cmp++; if (MEM_WRITE !== 1'b0) begin n_err++; $display("FAIL reset_mem_write: got %b want 0", MEM_WRITE); end
    n_cmp++; if (READDATA !== 8'h00) begin n_err++; $display("FAIL reset_readdata: got %h want 00", READDATA); end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_clean_read_miss();
    int s; logic [7:0] r; int rd0, wb0;
    rd0 = rd_count; wb0 = wb_count;
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, s, r);
    n_cmp++; if (s !== 8) begin n_err++; $display("FAIL clean_miss_stalls: got %0d want 8", s); end
    n_cmp++; if (r !== 8'h11) begin n_err++; $display("FAIL clean_miss_data: got %h want 11", r); end
    n_cmp++; if (rd_count !== rd0 + 1) begin n_err++; $display("FAIL clean_miss_fetches: got %0d want %0d", rd_count, rd0 + 1); end
    n_cmp++; if (rd_addr !== 6'h00) begin n_err++; $display("FAIL clean_miss_fetch_addr: got %h want 00", rd_addr); end
    n_cmp++; if (wb_count !== wb0) begin n_err++; $display("FAIL clean_miss_no_wb: got %0d want %0d", wb_count, wb0); end
  endtask

  task automatic test_read_hit();
    int s; logic [7:0] r; int rd0, wb0;
    logic [31:0] line;
    line = 32'h44332211;
    rd0 = rd_count; wb0 = wb_count;
    for (int off = 0; off < 4; off++) begin
      cpu_op(1'b1, 1'b0, 8'(off), 8'h00, s, r);
      n_cmp++; if (s !== 0) begin n_err++; $display("FAIL read_hit_stalls off %0d: got %0d want 0", off, s); end
      n_cmp++; if (r !== line[8*off +: 8]) begin n_err++; $display("FAIL read_hit_data off %0d: got %h want %h", off, r, line[8*off +: 8]); end
    end
    n_cmp++; if (rd_count !== rd0 || wb_count !== wb0) begin n_err++; $display("FAIL read_hit_mem_quiet: got rd %0d wb %0d want rd %0d wb %0d", rd_count, wb_count, rd0, wb0); end
  endtask

  task automatic test_write_hit();
    int s; logic [7:0] r; int rd0, wb0;
    rd0 = rd_count; wb0 = wb_count;
    cpu_op(1'b0, 1'b1, 8'h01, 8'hAB, s, r);
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL write_hit_stalls: got %0d want 0", s); end
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, s, r);
    n_cmp++; if (r !== 8'hAB) begin n_err++; $display("FAIL write_hit_readback: got %h want ab", r); end
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, s, r);
    n_cmp++; if (r !== 8'h11) begin n_err++; $display("FAIL write_hit_neighbour: got %h want 11", r); end
    n_cmp++; if (rd_count !== rd0 || wb_count !== wb0) begin n_err++; $display("FAIL write_hit_mem_quiet: got rd %0d wb %0d want rd %0d wb %0d", rd_count, wb_count, rd0, wb0); end
  endtask

  task automatic test_dirty_evict();
    int s; logic [7:0] r; int rd0, wb0;
    rd0 = rd_count; wb0 = wb_count;
    cpu_op(1'b1, 1'b0, 8'h20, 8'h00, s, r);
    n_cmp++; if (s !== 14) begin n_err++; $display("FAIL evict_stalls: got %0d want 14", s); end
    n_cmp++; if (r !== 8'h55) begin n_err++; $display("FAIL evict_data: got %h want 55", r); end
    n_cmp++; if (wb_count !== wb0 + 1) begin n_err++; $display("FAIL evict_wb_count: got %0d want %0d", wb_count, wb0 + 1); end
    n_cmp++; if (wb_addr !== 6'h00) begin n_err++; $display("FAIL evict_wb_addr: got %h want 00", wb_addr); end
    n_cmp++; if (wb_data !== 32'h4433AB11) begin n_err++; $display("FAIL evict_wb_data: got %h want 4433ab11", wb_data); end
    n_cmp++; if (rd_addr !== 6'h08) begin n_err++; $display("FAIL evict_fetch_addr: got %h want 08", rd_addr); end
    n_cmp++; if (rd_count !== rd0 + 1) begin n_err++; $display("FAIL evict_fetch_count: got %0d want %0d", rd_count, rd0 + 1); end
    // The freshly filled line is clean, so going back costs a fetch only.
    wb0 = wb_count;
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, s, r);
    n_cmp++; if (s !== 8) begin n_err++; $display("FAIL refill_stalls: got %0d want 8", s); end
    n_cmp++; if (r !== 8'hAB) begin n_err++; $display("FAIL refill_data: got %h want ab", r); end
    n_cmp++; if (wb_count !== wb0) begin n_err++; $display("FAIL refill_no_wb: got %0d want %0d", wb_count, wb0); end
  endtask

  task automatic test_write_miss();
    int s; logic [7:0] r; int wb0;
    wb0 = wb_count;
    cpu_op(1'b0, 1'b1, 8'h47, 8'hFF, s, r);
    n_cmp++; if (s !== 8) begin n_err++; $display("FAIL write_miss_stalls: got %0d want 8", s); end
    n_cmp++; if (rd_addr !== 6'h11) begin n_err++; $display("FAIL write_miss_fetch_addr: got %h want 11", rd_addr); end
    n_cmp++; if (wb_count !== wb0) begin n_err++; $display("FAIL write_miss_no_wb: got %0d want %0d", wb_count, wb0); end
    cpu_op(1'b1, 1'b0, 8'h47, 8'h00, s, r);
    n_cmp++; if (s !== 0 || r !== 8'hFF) begin n_err++; $display("FAIL write_miss_byte3: got %h stalls %0d want ff stalls 0", r, s); end
    cpu_op(1'b1, 1'b0, 8'h44, 8'h00, s, r);
    n_cmp++; if (r !== 8'hAA) begin n_err++; $display("FAIL write_miss_byte0: got %h want aa", r); end
    // Evicting the stored line proves it was left dirty.
    cpu_op(1'b1, 1'b0, 8'h64, 8'h00, s, r);
    n_cmp++; if (s !== 14) begin n_err++; $display("FAIL write_miss_evict_stalls: got %0d want 14", s); end
    n_cmp++; if (wb_addr !== 6'h11 || wb_data !== 32'hFFCCBBAA) begin n_err++; $display("FAIL write_miss_evict_wb: got %h/%h want 11/ffccbbaa", wb_addr, wb_data); end
    n_cmp++; if (r !== 8'h78) begin n_err++; $display("FAIL write_miss_evict_data: got %h want 78", r); end
  endtask

  task automatic test_back_to_back();
    int s; logic [7:0] r;
    // READ and WRITE together behave as a store: no load data is presented.
    cpu_op(1'b1, 1'b1, 8'h65, 8'h5A, s, r);
    n_cmp++; if (s !== 0 || r !== 8'h00) begin n_err++; $display("FAIL rw_both: got %h stalls %0d want 00 stalls 0", r, s); end
    cpu_op(1'b1, 1'b0, 8'h65, 8'h00, s, r);
    n_cmp++; if (r !== 8'h5A) begin n_err++; $display("FAIL rw_both_readback: got %h want 5a", r); end
    cpu_op(1'b1, 1'b0, 8'h66, 8'h00, s, r);
    n_cmp++; if (r !== 8'h34) begin n_err++; $display("FAIL b2b_byte2: got %h want 34", r); end
    #1;
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_err++; $display("FAIL idle_busywait: got %b want 0", BUSYWAIT); end
  endtask

  task automatic test_reset_mid_miss();
    int s; logic [7:0] r;
    READ = 1'b1;
    WRITE = 1'b0;
    ADDRESS = 8'h08;
    repeat (3) @(negedge CLK);
    n_cmp++; if (MEM_READ !== 1'b1) begin n_err++; $display("FAIL mid_miss_fetching: got %b want 1", MEM_READ); end
    RESET = 1'b0;
    READ = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_err++; $display("FAIL abort_mem_req: got rd %b wr %b want 0 0", MEM_READ, MEM_WRITE); end
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_err++; $display("FAIL abort_busywait: got %b want 0", BUSYWAIT); end
    n_cmp++; if (READDATA !== 8'h00) begin n_err++; $display("FAIL abort_readdata: got %h want 00", READDATA); end
    @(negedge CLK);
    RESET = 1'b1;
    // Line 0 was valid before reset; it must miss now.
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, s, r);
    n_cmp++; if (s !== 8) begin n_err++; $display("FAIL post_reset_miss_stalls: got %0d want 8", s); end
    n_cmp++; if (r !== 8'h11) begin n_err++; $display("FAIL post_reset_data: got %h want 11", r); end
    n_cmp++; if (both_seen !== 1'b0) begin n_err++; $display("FAIL mem_rd_wr_overlap: got %b want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_clean_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_back_to_back();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
